// File: rtl/csr_pkg.sv
// Shared types and helpers for the CSR row engine.
// The CSR_SAT_EN macro (see csr_row_engine) selects saturating accumulation via sat_add.
package csr_pkg;

   localparam int CSR_DATA_W = 8;
   localparam int CSR_ACC_W  = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LEN_WAIT = 2'd1,
      STREAM   = 2'd2,
      EMIT     = 2'd3
   } state_t;

   // Signed add clamped to the accumulator range instead of wrapping.
   function automatic logic signed [CSR_ACC_W-1:0] sat_add(
      input logic signed [CSR_ACC_W-1:0] a,
      input logic signed [CSR_ACC_W-1:0] b
   );
      logic signed [CSR_ACC_W:0] s;
      s = {a[CSR_ACC_W-1], a} + {b[CSR_ACC_W-1], b};
      if (s[CSR_ACC_W] != s[CSR_ACC_W-1]) begin
         if (s[CSR_ACC_W]) begin
            sat_add = {1'b1, {(CSR_ACC_W-1){1'b0}}};
         end else begin
            sat_add = {1'b0, {(CSR_ACC_W-1){1'b1}}};
         end
      end else begin
         sat_add = s[CSR_ACC_W-1:0];
      end
   endfunction

endpackage

// File: rtl/vec_ram.sv
// Dense input vector storage: synchronous write, asynchronous read.
// A read of the address being written in the same cycle returns the old word.
module vec_ram #(
   parameter int DEPTH = 256,
   parameter int W     = 8,
   parameter int AW    = 8
)(
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [0:DEPTH-1];

   // Write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/csr_row_engine.sv
// Drains len/val/col FIFOs and emits one signed CSR row dot-product per length word.
// Define CSR_SAT_EN for saturating accumulation; otherwise the accumulator wraps.
module csr_row_engine
   import csr_pkg::*;
#(
   parameter int DATA_W    = CSR_DATA_W,
   parameter int ACC_W     = CSR_ACC_W,
   parameter int VEC_DEPTH = 1 << DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] len_in,
   input  logic              len_empty,
   output logic              len_read,
   input  logic [DATA_W-1:0] val_in,
   input  logic              val_empty,
   output logic              val_read,
   input  logic [DATA_W-1:0] col_in,
   input  logic              col_empty,
   output logic              col_read,
   input  logic              vec_we,
   input  logic [DATA_W-1:0] vec_addr,
   input  logic [DATA_W-1:0] vec_wdata,
   output logic [ACC_W-1:0]  row_out,
   output logic [15:0]       row_idx,
   output logic              row_valid,
   input  logic              row_ready
);

   localparam logic [DATA_W-1:0] ONE_D  = DATA_W'(1);
   localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [DATA_W-1:0]          r_len;
   logic [DATA_W-1:0]          r_issued;
   logic [DATA_W-1:0]          r_accepted;
   logic                       r_d1;
   logic signed [ACC_W-1:0]    r_acc;
   logic [15:0]                r_row_idx;
   logic                       w_pop;
   logic [DATA_W-1:0]          w_vec_rdata;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_prod_ext;
   logic signed [ACC_W-1:0]    w_acc_sum;

   vec_ram #(
      .DEPTH (VEC_DEPTH),
      .W     (DATA_W),
      .AW    (DATA_W)
   ) u_vec_ram (
      .clk     (clk),
      .i_we    (vec_we),
      .i_waddr (vec_addr),
      .i_wdata (vec_wdata),
      .i_raddr (col_in),
      .o_rdata (w_vec_rdata)
   );

   assign w_pop      = (r_state == STREAM) && (r_issued < r_len) && !val_empty && !col_empty;
   assign w_prod     = $signed(val_in) * $signed(w_vec_rdata);
   assign w_prod_ext = ACC_W'(w_prod);

`ifdef CSR_SAT_EN
   assign w_acc_sum = sat_add(r_acc, w_prod_ext);
`else
   assign w_acc_sum = r_acc + w_prod_ext;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and FIFO/handshake strobes; len_read is masked while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      len_read    = 1'b0;
      val_read    = 1'b0;
      col_read    = 1'b0;
      row_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            if (rst && !len_empty) begin
               len_read    = 1'b1;
               w_state_nxt = LEN_WAIT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LEN_WAIT: begin
            if (len_in == ZERO_D) begin
               w_state_nxt = EMIT;
            end else begin
               w_state_nxt = STREAM;
            end
         end
         STREAM: begin
            val_read = w_pop;
            col_read = w_pop;
            if (r_d1 && ((r_accepted + ONE_D) == r_len)) begin
               w_state_nxt = EMIT;
            end else begin
               w_state_nxt = STREAM;
            end
         end
         EMIT: begin
            row_valid = 1'b1;
            if (row_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = EMIT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Row datapath: d1 marks the cycle in which the popped FIFO words are valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_len      <= ZERO_D;
         r_issued   <= ZERO_D;
         r_accepted <= ZERO_D;
         r_d1       <= 1'b0;
         r_acc      <= {ACC_W{1'b0}};
         r_row_idx  <= 16'd0;
      end else begin
         case (r_state)
            LEN_WAIT: begin
               r_len      <= len_in;
               r_issued   <= ZERO_D;
               r_accepted <= ZERO_D;
               r_d1       <= 1'b0;
               r_acc      <= {ACC_W{1'b0}};
            end
            STREAM: begin
               r_d1 <= w_pop;
               if (w_pop) begin
                  r_issued <= r_issued + ONE_D;
               end
               if (r_d1) begin
                  r_acc      <= w_acc_sum;
                  r_accepted <= r_accepted + ONE_D;
               end
            end
            EMIT: begin
               if (row_ready) begin
                  r_row_idx <= r_row_idx + 16'd1;
               end
            end
            default: begin
               r_d1 <= 1'b0;
            end
         endcase
      end
   end

   assign row_out = r_acc;
   assign row_idx = r_row_idx;

endmodule

// File: tb/tb_csr_row_engine.sv
// Self-checking bench for csr_row_engine: table vectors, corner-case sequences, random rows.
module tb_csr_row_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  len_in, val_in, col_in;
   logic        len_empty, val_empty, col_empty;
   logic        len_read, val_read, col_read;
   logic        vec_we;
   logic [7:0]  vec_addr, vec_wdata;
   logic [15:0] row_out, row_idx;
   logic        row_valid, row_ready;

   always #5 clk = ~clk;

   csr_row_engine dut (
      .clk(clk), .rst(rst),
      .len_in(len_in), .len_empty(len_empty), .len_read(len_read),
      .val_in(val_in), .val_empty(val_empty), .val_read(val_read),
      .col_in(col_in), .col_empty(col_empty), .col_read(col_read),
      .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
      .row_out(row_out), .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready)
   );

   // Standard-read FIFO models (dout registered on the pop edge)
   logic [7:0] len_mem [0:4095];
   logic [7:0] val_mem [0:4095];
   logic [7:0] col_mem [0:4095];
   int len_wp, len_rp, val_wp, val_rp, col_wp, col_rp;
   int cyc, pop_viol;
   logic force_val, force_col, flush;

   assign len_empty = (len_wp == len_rp);
   assign val_empty = (val_wp == val_rp) || force_val;
   assign col_empty = (col_wp == col_rp) || force_col;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (flush) begin
         len_rp <= len_wp;
         val_rp <= val_wp;
         col_rp <= col_wp;
      end else begin
         if ((len_read && len_empty) || (val_read && val_empty) ||
             (col_read && col_empty) || (val_read != col_read))
            pop_viol <= pop_viol + 1;
         if (len_read && !len_empty) begin
            len_in <= len_mem[len_rp];
            len_rp <= len_rp + 1;
         end
         if (val_read && !val_empty) begin
            val_in <= val_mem[val_rp];
            val_rp <= val_rp + 1;
         end
         if (col_read && !col_empty) begin
            col_in <= col_mem[col_rp];
            col_rp <= col_rp + 1;
         end
      end
   end

   // Reference state
   int ref_vec [0:255];
   int r_n;
   int r_cols [0:15];
   int r_vals [0:15];
   int exp_idx;
   int n_checks, n_err;

   typedef struct packed {
      logic [7:0]       len;
      logic [3:0][7:0]  cols;
      logic [3:0][7:0]  vals;
      logic signed [15:0] exp_out;
   } vec_t;

   vec_t tbl [0:5];

   function automatic vec_t mk(int len, int c0, int c1, int c2, int c3,
                               int v0, int v1, int v2, int v3, int e);
      vec_t r;
      r.len     = 8'(len);
      r.cols    = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
      r.vals    = {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
      r.exp_out = 16'(e);
      return r;
   endfunction

   function automatic int to_s8(int d);
      return (d > 127) ? d - 256 : d;
   endfunction

   // Row sum from the arithmetic definition: sum of val*vec[col], wrapped or clamped per add
   function automatic int model_row();
      int acc;
      int p;
      logic signed [15:0] w;
      acc = 0;
      for (int i = 0; i < r_n; i++) begin
         p = r_vals[i] * ref_vec[r_cols[i]];
`ifdef CSR_SAT_EN
         acc = acc + p;
         if (acc > 32767) acc = 32767;
         else if (acc < -32768) acc = -32768;
`else
         w   = 16'(acc + p);
         acc = int'(w);
`endif
      end
      return acc;
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks = n_checks + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_row();
      len_mem[len_wp] = 8'(r_n);
      len_wp = len_wp + 1;
      for (int i = 0; i < r_n; i++) begin
         val_mem[val_wp] = 8'(r_vals[i]);
         col_mem[col_wp] = 8'(r_cols[i]);
         val_wp = val_wp + 1;
         col_wp = col_wp + 1;
      end
   endtask

   task automatic wait_len(output int c0);
      c0 = -1;
      #1;
      for (int k = 0; k < 50 && c0 < 0; k++) begin
         if (len_read) c0 = cyc;
         else @(negedge clk);
      end
      check("len_read_seen", (c0 >= 0) ? 1 : 0, 1);
   endtask

   task automatic wait_valid(input int c0, input bit rnd, output int lat);
      int v;
      v = -1;
      for (int k = 0; k < 400 && v < 0; k++) begin
         @(negedge clk);
         if (row_valid) begin
            v = cyc;
         end else if (rnd) begin
            force_val = ($urandom_range(3) == 0);
            force_col = ($urandom_range(3) == 0);
         end
      end
      force_val = 1'b0;
      force_col = 1'b0;
      check("row_valid_seen", (v >= 0) ? 1 : 0, 1);
      lat = v - c0;
   endtask

   task automatic handshake();
      row_ready = 1'b1;
      @(negedge clk);
      check("valid_drop", int'(row_valid), 0);
      row_ready = 1'b0;
      exp_idx = (exp_idx + 1) % 65536;
   endtask

   task automatic do_row(string name, int exp_out, int exp_lat, bit rnd);
      int c0, lat;
      push_row();
      wait_len(c0);
      wait_valid(c0, rnd, lat);
      if (exp_lat >= 0) check({name, "_lat"}, lat, exp_lat);
      check({name, "_out"}, int'($signed(row_out)), exp_out);
      check({name, "_idx"}, int'(row_idx), exp_idx);
      handshake();
   endtask

   task automatic vec_load_seq(bit rnd);
      int d;
      for (int i = 0; i < 256; i++) begin
         d = rnd ? int'($urandom_range(255)) : i;
         vec_we    = 1'b1;
         vec_addr  = 8'(i);
         vec_wdata = 8'(d);
         ref_vec[i] = to_s8(d);
         @(negedge clk);
      end
      vec_we = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, lat, pv, pc, exp_a, exp_b, hold;
      rst = 1'b0; row_ready = 1'b0; vec_we = 1'b0; vec_addr = 8'd0; vec_wdata = 8'd0;
      force_val = 1'b0; force_col = 1'b0; flush = 1'b0;
      n_checks = 0; n_err = 0; exp_idx = 0;

      tbl[0] = mk(3,   1,   2, 3, 0,    2,  -1,   4,  0,    12);
      tbl[1] = mk(0,   0,   0, 0, 0,    0,   0,   0,  0,     0);
      tbl[2] = mk(1, 100,   0, 0, 0,   -3,   0,   0,  0,  -300);
      tbl[3] = mk(4,  10,  20, 30, 40,  1,   1,   1,  1,   100);
      tbl[4] = mk(2, 200, 255, 0, 0,    2,  -1,   0,  0,  -111);
      tbl[5] = mk(4, 127,   0, 127, 1, -128, 5, 100, -7, -3563);

      repeat (3) @(negedge clk);
      check("rst_row_valid", int'(row_valid), 0);
      check("rst_row_out",   int'(row_out),   0);
      check("rst_row_idx",   int'(row_idx),   0);
      check("rst_len_read",  int'(len_read),  0);
      check("rst_val_read",  int'(val_read),  0);
      rst = 1'b1;
      @(negedge clk);

      vec_load_seq(1'b0);

      for (int k = 0; k < 6; k++) begin
         r_n = int'(tbl[k].len);
         for (int i = 0; i < 4; i++) begin
            r_cols[i] = int'(tbl[k].cols[i]);
            r_vals[i] = to_s8(int'(tbl[k].vals[i]));
         end
         do_row("tbl", int'(tbl[k].exp_out), (r_n == 0) ? 2 : r_n + 3, 1'b0);
      end

      // Overflow row: 3 x 127*127
      vec_we = 1'b1; vec_addr = 8'd5; vec_wdata = 8'd127; ref_vec[5] = 127;
      @(negedge clk);
      vec_we = 1'b0;
      r_n = 3;
      for (int i = 0; i < 3; i++) begin r_cols[i] = 5; r_vals[i] = 127; end
`ifdef CSR_SAT_EN
      do_row("sat", 32767, 6, 1'b0);
`else
      do_row("wrap", -17149, 6, 1'b0);
`endif

      // Column FIFO held empty for 4 cycles mid-row
      r_n = 4;
      r_cols[0] = 3; r_cols[1] = 4; r_cols[2] = 6; r_cols[3] = 7;
      r_vals[0] = 10; r_vals[1] = -20; r_vals[2] = 30; r_vals[3] = -40;
      exp_a = model_row();
      push_row();
      wait_len(c0);
      repeat (3) @(negedge clk);
      force_col = 1'b1;
      pv = val_rp; pc = col_rp;
      repeat (4) @(negedge clk);
      check("stall_val_pops", val_rp - pv, 0);
      check("stall_col_pops", col_rp - pc, 0);
      force_col = 1'b0;
      wait_valid(c0, 1'b0, lat);
      check("stall_lat", lat, 11);
      check("stall_out", int'($signed(row_out)), exp_a);
      check("stall_idx", int'(row_idx), exp_idx);
      handshake();

      // Backpressure with a second row already queued
      r_n = 2; r_cols[0] = 7; r_cols[1] = 8; r_vals[0] = 3; r_vals[1] = 3;
      exp_a = model_row();
      push_row();
      r_n = 1; r_cols[0] = 9; r_vals[0] = 2;
      exp_b = model_row();
      push_row();
      wait_len(c0);
      wait_valid(c0, 1'b0, lat);
      check("bp_lat", lat, 5);
      hold = int'($signed(row_out));
      check("bp_out", hold, exp_a);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_stable", int'($signed(row_out)), hold);
         check("bp_no_len_read", int'(len_read), 0);
         check("bp_valid_held", int'(row_valid), 1);
      end
      check("bp_idx", int'(row_idx), exp_idx);
      row_ready = 1'b1;
      @(negedge clk);
      row_ready = 1'b0;
      exp_idx = exp_idx + 1;
      check("bp_valid_drop", int'(row_valid), 0);
      check("bp_next_len_read", int'(len_read), 1);
      c0 = cyc;
      wait_valid(c0, 1'b0, lat);
      check("bp2_lat", lat, 4);
      check("bp2_out", int'($signed(row_out)), exp_b);
      check("bp2_idx", int'(row_idx), exp_idx);
      handshake();

      // Reset in the middle of STREAM, another length word pending
      r_n = 4;
      for (int i = 0; i < 4; i++) begin r_cols[i] = i + 1; r_vals[i] = 5; end
      push_row();
      push_row();
      wait_len(c0);
      repeat (4) @(negedge clk);
      check("pre_rst_out_nonzero", (row_out != 16'd0) ? 1 : 0, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_len_read",  int'(len_read),  0);
      check("mid_rst_val_read",  int'(val_read),  0);
      check("mid_rst_col_read",  int'(col_read),  0);
      check("mid_rst_row_valid", int'(row_valid), 0);
      check("mid_rst_row_out",   int'(row_out),   0);
      check("mid_rst_row_idx",   int'(row_idx),   0);
      exp_idx = 0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      r_n = 3;
      r_cols[0] = 10; r_cols[1] = 11; r_cols[2] = 12;
      r_vals[0] = -1; r_vals[1] = 2;  r_vals[2] = -3;
      do_row("post_rst", model_row(), 6, 1'b0);

      // Random vector contents and rows, alternately with random FIFO stalls
      vec_load_seq(1'b1);
      for (int k = 0; k < 24; k++) begin
         r_n = int'($urandom_range(10));
         for (int i = 0; i < r_n; i++) begin
            r_cols[i] = int'($urandom_range(255));
            r_vals[i] = int'($urandom_range(255)) - 128;
         end
         if (k % 2 == 0) do_row("rnd_stall", model_row(), -1, 1'b1);
         else            do_row("rnd", model_row(), (r_n == 0) ? 2 : r_n + 3, 1'b0);
      end

      check("pop_protocol", pop_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
